// File: rtl/cat_pkg.sv
// Shared types and ASCII constants for the cat command decoder and its helpers.
package cat_pkg;

  localparam int NUM_CATS = 8;

  localparam logic [7:0] CMD_HEX   = 8'h23;
  localparam logic [7:0] CMD_QUERY = 8'h3F;
  localparam logic [7:0] CLR_BASE  = 8'h41;
  localparam logic [7:0] SET_BASE  = 8'h61;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SP    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEX_HI = 2'd1,
    S_HEX_LO = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/cat_cmd_decoder_if.sv
// Byte-stream handshake between the UART rx/tx paths and the command decoder.
interface cat_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready,
                  input tx_data, input tx_valid, output tx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready,
                  output tx_data, output tx_valid, input tx_ready);
endinterface

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder, case-insensitive.
module hex_nibble_decode (
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic [3:0] nibble
);
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = byte_in[3:0];
    end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                 (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = byte_in[3:0] + 4'd9;
    end
  end
endmodule

// File: rtl/cat_cmd_decoder.sv
// Framed command decoder: single-letter set/clear, '#hh' mask write, '?' status query.
module cat_cmd_decoder
  import cat_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = 10_334_000,
  parameter logic [NUM_CATS-1:0]   RESET_MASK     = 8'hFF
) (
  input  logic                clk,
  input  logic                reset_n,
  cat_cmd_decoder_if.slave    bus,
  output logic [NUM_CATS-1:0] cat_status,
  output logic [7:0]          err_count,
  output logic                busy
);
  // state    | meaning
  // S_IDLE   | waiting for a command byte
  // S_HEX_HI | '#' seen, expecting high hex digit
  // S_HEX_LO | high digit stored, expecting low hex digit
  // S_RESP   | status byte offered to transmitter, rx stalled

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [3:0]           hi_q, hi_nxt;
  logic [CW-1:0]        tmr_q, tmr_nxt;
  logic [NUM_CATS-1:0]  cat_nxt;
  logic [7:0]           tx_data_q, tx_data_nxt;
  logic                 tx_valid_q, tx_valid_nxt;
  logic                 err_inc;
  logic                 accept;
  logic                 is_hex;
  logic [3:0]           nib;
  logic [2:0]           bit_idx;

  hex_nibble_decode u_hex (
    .byte_in (bus.rx_data),
    .is_hex  (is_hex),
    .nibble  (nib)
  );

  assign bus.rx_ready = (state != S_RESP);
  assign busy         = (state != S_IDLE);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign accept       = bus.rx_valid && bus.rx_ready;
  // Both letter bases end in 3'b001, so the low bits minus one give the cat index.
  assign bit_idx      = bus.rx_data[2:0] - 3'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hi_q       <= 4'h0;
      tmr_q      <= '0;
      cat_status <= RESET_MASK;
      err_count  <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      hi_q       <= hi_nxt;
      tmr_q      <= tmr_nxt;
      cat_status <= cat_nxt;
      tx_data_q  <= tx_data_nxt;
      tx_valid_q <= tx_valid_nxt;
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    hi_nxt       = hi_q;
    tmr_nxt      = '0;
    cat_nxt      = cat_status;
    err_inc      = 1'b0;
    tx_data_nxt  = tx_data_q;
    tx_valid_nxt = tx_valid_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.rx_data >= CLR_BASE && bus.rx_data <= CLR_BASE + 8'd7)
            cat_nxt[bit_idx] = 1'b0;
          else if (bus.rx_data >= SET_BASE && bus.rx_data <= SET_BASE + 8'd7)
            cat_nxt[bit_idx] = 1'b1;
          else if (bus.rx_data == CMD_HEX)
            state_nxt = S_HEX_HI;
          else if (bus.rx_data == CMD_QUERY) begin
            state_nxt    = S_RESP;
            tx_data_nxt  = cat_status;
            tx_valid_nxt = 1'b1;
          end else if (bus.rx_data != CHR_LF && bus.rx_data != CHR_CR &&
                       bus.rx_data != CHR_SP)
            err_inc = 1'b1;
        end
      end
      S_HEX_HI, S_HEX_LO: begin
        // An accepted byte takes priority over an expiring timer.
        if (accept) begin
          if (!is_hex) begin
            err_inc   = 1'b1;
            state_nxt = S_IDLE;
          end else if (state == S_HEX_HI) begin
            hi_nxt    = nib;
            state_nxt = S_HEX_LO;
          end else begin
            cat_nxt   = {hi_q, nib};
            state_nxt = S_IDLE;
          end
        end else if (tmr_q == TC_LAST) begin
          err_inc   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cat_cmd_decoder.sv
// Scoreboard bench for cat_cmd_decoder: stimulus pushes expected output events, a monitor checks them.
module tb_cat_cmd_decoder;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cat_status;
  logic [7:0] err_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_cat[$];
  logic [7:0] exp_err[$];
  logic [7:0] exp_tx[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_cat, prev_err;
  int         m_err;

  cat_cmd_decoder_if bus ();

  cat_cmd_decoder #(.TIMEOUT_CYCLES(16), .RESET_MASK(8'hFF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .cat_status (cat_status),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cat_status !== prev_cat) begin
        if (exp_cat.size() == 0) chk("cat_unexpected_change", cat_status, prev_cat);
        else chk("cat_status", cat_status, exp_cat.pop_front());
        prev_cat = cat_status;
      end
      if (err_count !== prev_err) begin
        if (exp_err.size() == 0) chk("err_unexpected_change", err_count, prev_err);
        else chk("err_count", err_count, exp_err.pop_front());
        prev_err = err_count;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", bus.tx_data, 8'h00);
        else chk("tx_data", bus.tx_data, exp_tx.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!bus.rx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rx_ready) chk("rx_ready_wait", {7'd0, bus.rx_ready}, 8'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_cat", cat_status, 8'hFF);
    chk("rst_err", err_count, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_rx_ready", {7'd0, bus.rx_ready}, 8'd1);
    chk("rst_tx_valid", {7'd0, bus.tx_valid}, 8'd0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    prev_cat = cat_status;
    prev_err = err_count;
    mon_en   = 1'b1;
    m_err    = 0;

    // Single-letter clear/set
    exp_cat.push_back(8'hFB);
    send_byte("C");
    send_byte("a");
    gap(1);
    chk("after_a_cat", cat_status, 8'hFB);
    chk("after_a_err", err_count, 8'h00);

    // Hex frame with gaps
    send_byte("#");
    chk("hex_busy_hi", {7'd0, busy}, 8'd1);
    gap(5);
    send_byte("3");
    chk("hex_busy_lo", {7'd0, busy}, 8'd1);
    chk("hex_cat_pending", cat_status, 8'hFB);
    gap(5);
    exp_cat.push_back(8'h3C);
    send_byte("c");
    chk("hex_busy_done", {7'd0, busy}, 8'd0);

    // Bad hex digit, then a clear on an already-clear bit and a live bit
    exp_err.push_back(8'd1); m_err = 1;
    send_byte("#");
    send_byte("Z");
    chk("badhex_idle", {7'd0, busy}, 8'd0);
    send_byte("B");
    gap(1);
    chk("clr_b_cat", cat_status, 8'h3C);
    exp_cat.push_back(8'h34);
    send_byte("D");

    // Inter-byte timeout
    exp_err.push_back(8'd2); m_err = 2;
    send_byte("#");
    send_byte("5");
    gap(15);
    chk("timeout_early_busy", {7'd0, busy}, 8'd1);
    gap(1);
    chk("timeout_fire_busy", {7'd0, busy}, 8'd0);

    // Query with stalled transmitter; rx traffic during RESP must be ignored
    exp_cat.push_back(8'hA5);
    send_byte("#");
    send_byte("A");
    send_byte("5");
    exp_tx.push_back(8'hA5);
    send_byte("?");
    bus.rx_valid = 1'b1;
    bus.rx_data  = "A";
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("resp_tx_valid", {7'd0, bus.tx_valid}, 8'd1);
      chk("resp_tx_data", bus.tx_data, 8'hA5);
      chk("resp_rx_ready", {7'd0, bus.rx_ready}, 8'd0);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    chk("resp_done_tx_valid", {7'd0, bus.tx_valid}, 8'd0);
    chk("resp_done_rx_ready", {7'd0, bus.rx_ready}, 8'd1);
    chk("resp_done_busy", {7'd0, busy}, 8'd0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      if (m_err != 255) begin
        m_err++;
        exp_err.push_back(8'(m_err));
      end
      send_byte("Q");
    end
    gap(1);
    chk("err_saturated", err_count, 8'hFF);

    // Reset in the middle of a hex frame
    send_byte("#");
    send_byte("3");
    exp_cat.push_back(8'hFF);
    exp_err.push_back(8'h00);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_rx_ready", {7'd0, bus.rx_ready}, 8'd1);
    chk("midrst_tx_valid", {7'd0, bus.tx_valid}, 8'd0);
    chk("midrst_cat", cat_status, 8'hFF);
    chk("midrst_err", err_count, 8'h00);
    gap(2);

    chk("cat_queue_left", 8'(exp_cat.size()), 8'd0);
    chk("err_queue_left", 8'(exp_err.size()), 8'd0);
    chk("tx_queue_left", 8'(exp_tx.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
